// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding and the
// {previous, current} patterns used to recognise edges on synchronised inputs.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        WAIT_CS_HIGH = 2'd0,
        IDLE         = 2'd1,
        ACTIVE       = 2'd2,
        DONE         = 2'd3
    } spi_state_t;

    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-stage synchroniser for one SPI pin, with optional single-cycle
// rise/fall strobes derived from one extra history flop.
module spi_in_sync
    import spi_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_VAL   = 1'b0,
    parameter bit EDGE_EN     = 1'b1
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic r_prev;

            always_ff @(posedge i_clk) begin
                if (!i_rstn) begin
                    r_prev <= RESET_VAL;
                end else begin
                    r_prev <= r_sync[SYNC_STAGES-1];
                end
            end

            assign o_rise = ({r_prev, o_level} == EDGE_RISE);
            assign o_fall = ({r_prev, o_level} == EDGE_FALL);
        end else begin : g_no_edge
            assign o_rise = 1'b0;
            assign o_fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/spi_slave_interface.sv
// SPI responder (CPOL=0, sample on SCLK rise, MSB first) oversampled in clk.
// Define SPI_SLAVE_LSB_FIRST_EN to make both directions LSB first.
module spi_slave_interface
    import spi_slave_pkg::*;
#(
    parameter int parallel_data_length = 32,
    parameter int sync_stages          = 2
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [parallel_data_length-1:0] tx_data_in,
    input  logic                            spi_cs_n_in,
    input  logic                            spi_sclk_in,
    input  logic                            spi_sdata_in,
    output logic                            spi_sdata_out,
    output logic                            spi_sdata_oe,
    output logic                            tx_taken,
    output logic [parallel_data_length-1:0] rx_data_out,
    output logic                            rx_data_valid,
    output logic                            frame_err,
    output logic                            busy
);

    localparam int         N        = parallel_data_length;
    localparam logic [7:0] LAST_BIT = 8'(N - 1);
    localparam logic [7:0] SETTLE   = 8'(sync_stages);

    logic w_cs_s, w_cs_rise, w_cs_fall;
    logic w_sclk_level_unused, w_sclk_rise, w_sclk_fall;
    logic w_mosi_s, w_mosi_rise_unused, w_mosi_fall_unused;

    spi_in_sync #(.SYNC_STAGES(sync_stages), .RESET_VAL(1'b1), .EDGE_EN(1'b1)) u_cs_sync (
        .i_clk(clk), .i_rstn(rstn), .i_pin(spi_cs_n_in),
        .o_level(w_cs_s), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    spi_in_sync #(.SYNC_STAGES(sync_stages), .RESET_VAL(1'b0), .EDGE_EN(1'b1)) u_sclk_sync (
        .i_clk(clk), .i_rstn(rstn), .i_pin(spi_sclk_in),
        .o_level(w_sclk_level_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_in_sync #(.SYNC_STAGES(sync_stages), .RESET_VAL(1'b0), .EDGE_EN(1'b0)) u_mosi_sync (
        .i_clk(clk), .i_rstn(rstn), .i_pin(spi_sdata_in),
        .o_level(w_mosi_s), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
    );

    spi_state_t   r_state, w_state_next;
    logic [7:0]   r_bit_cnt;
    logic [N-1:0] r_shift_tx;   // bits not yet presented on MISO
    logic [N-2:0] r_shift_rx;   // all but the newest bit of the incoming word
    logic [N-1:0] r_rx_data;
    logic         r_sdo, r_oe, r_tx_taken, r_rx_valid, r_frame_err;

    logic         w_settle, w_load, w_shift_in, w_shift_out, w_done, w_abort;
    logic [N-1:0] w_rx_next, w_tx_load, w_tx_shifted;
    logic         w_tx_first, w_tx_next_bit;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign w_rx_next     = {w_mosi_s, r_shift_rx};
    assign w_tx_first    = tx_data_in[0];
    assign w_tx_load     = {1'b0, tx_data_in[N-1:1]};
    assign w_tx_next_bit = r_shift_tx[0];
    assign w_tx_shifted  = {1'b0, r_shift_tx[N-1:1]};
`else
    assign w_rx_next     = {r_shift_rx, w_mosi_s};
    assign w_tx_first    = tx_data_in[N-1];
    assign w_tx_load     = {tx_data_in[N-2:0], 1'b0};
    assign w_tx_next_bit = r_shift_tx[N-1];
    assign w_tx_shifted  = {r_shift_tx[N-2:0], 1'b0};
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= WAIT_CS_HIGH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // After reset, bit_cnt counts out the synchroniser depth so a CS that is
    // still low is seen as low before IDLE can be entered.
    always_comb begin
        w_state_next = r_state;
        w_settle     = 1'b0;
        w_load       = 1'b0;
        w_shift_in   = 1'b0;
        w_shift_out  = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            WAIT_CS_HIGH: begin
                if (r_bit_cnt < SETTLE) begin
                    w_settle = 1'b1;
                end else if (w_cs_s) begin
                    w_state_next = IDLE;
                end
            end
            IDLE: begin
                if (w_cs_fall) begin
                    w_load       = 1'b1;
                    w_state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_cs_rise) begin
                    w_abort      = 1'b1;
                    w_state_next = IDLE;
                end else if (w_sclk_rise) begin
                    w_shift_in = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_done       = 1'b1;
                        w_state_next = DONE;
                    end
                end else if (w_sclk_fall && (r_bit_cnt != 8'd0)) begin
                    w_shift_out = 1'b1;
                end
            end
            DONE: begin
                if (w_cs_rise) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = WAIT_CS_HIGH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_bit_cnt   <= '0;
            r_shift_tx  <= '0;
            r_shift_rx  <= '0;
            r_rx_data   <= '0;
            r_sdo       <= 1'b0;
            r_oe        <= 1'b0;
            r_tx_taken  <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_tx_taken  <= w_load;
            r_rx_valid  <= w_done;
            r_frame_err <= w_abort;
            r_oe        <= ~w_cs_s;
            if (w_settle) r_bit_cnt <= r_bit_cnt + 8'd1;
            if (w_load) begin
                r_bit_cnt  <= '0;
                r_shift_tx <= w_tx_load;
            end
            if (w_shift_in) begin
                r_shift_rx <= w_rx_next[N-2:0];
`ifdef SPI_SLAVE_LSB_FIRST_EN
                r_shift_rx <= w_rx_next[N-1:1];
`endif
                r_bit_cnt  <= r_bit_cnt + 8'd1;
            end
            if (w_done) r_rx_data <= w_rx_next;
            if (w_shift_out) r_shift_tx <= w_tx_shifted;
            if (w_load) begin
                r_sdo <= w_tx_first;
            end else if (w_cs_s || w_done || (r_state == DONE)) begin
                r_sdo <= 1'b0;
            end else if (w_shift_out) begin
                r_sdo <= w_tx_next_bit;
            end
        end
    end

    assign spi_sdata_out = r_sdo;
    assign spi_sdata_oe  = r_oe;
    assign tx_taken      = r_tx_taken;
    assign rx_data_out   = r_rx_data;
    assign rx_data_valid = r_rx_valid;
    assign frame_err     = r_frame_err;
    assign busy          = (r_state == ACTIVE) || (r_state == DONE);

endmodule

// File: tb/tb_spi_slave_interface.sv
// Self-checking bench for spi_slave_interface: a bit-banged SPI master drives
// frames; a frame-level model predicts received words, errors and MISO words.
module tb_spi_slave_interface;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [N-1:0] tx_data_in = '0;
    logic         cs_n = 1'b1;
    logic         sclk = 1'b0;
    logic         mosi = 1'b0;
    logic         spi_sdata_out, spi_sdata_oe, tx_taken, rx_data_valid, frame_err, busy;
    logic [N-1:0] rx_data_out;

    always #5 clk = ~clk;

    spi_slave_interface #(.parallel_data_length(N), .sync_stages(2)) dut (
        .clk(clk), .rstn(rstn), .tx_data_in(tx_data_in),
        .spi_cs_n_in(cs_n), .spi_sclk_in(sclk), .spi_sdata_in(mosi),
        .spi_sdata_out(spi_sdata_out), .spi_sdata_oe(spi_sdata_oe),
        .tx_taken(tx_taken), .rx_data_out(rx_data_out),
        .rx_data_valid(rx_data_valid), .frame_err(frame_err), .busy(busy)
    );

    int           checks = 0;
    int           failures = 0;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] hold_model = '0;
    logic [N-1:0] popped;
    int           exp_err = 0, err_seen = 0, exp_taken = 0, taken_seen = 0;

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Position in the word of the k-th bit on the wire.
    function automatic int bitpos(input int k);
`ifdef SPI_SLAVE_LSB_FIRST_EN
        return k;
`else
        return N - 1 - k;
`endif
    endfunction

    // Compare process: every cycle out of reset, rx_data_out must either hold
    // the last expected word or present the next queued word with a valid pulse.
    always @(negedge clk) begin
        if (!rstn) begin
            hold_model = '0;
        end else begin
            if (tx_taken) taken_seen++;
            if (frame_err) err_seen++;
            if (rx_data_valid) begin
                if (exp_q.size() == 0) begin
                    check_bit("rx_valid_unexpected", rx_data_valid, 1'b0);
                end else begin
                    popped = exp_q.pop_front();
                    check_word("rx_word", rx_data_out, popped);
                    hold_model = popped;
                end
            end else begin
                check_word("rx_hold", rx_data_out, hold_model);
            end
        end
    end

    // One CS window of nbits SCLK cycles (SCLK = clk/8). Bits past N are 1.
    // rst_bit >= 0 pulses rstn just before that bit, leaving CS low.
    task automatic spi_frame(input logic [N-1:0] tx_w, input logic [N-1:0] mosi_w,
                             input int nbits, input int rst_bit, output logic [N-1:0] miso_w);
        logic [N-1:0] mask;
        miso_w = '0;
        mask   = '0;
        @(negedge clk);
        tx_data_in = tx_w;
        exp_taken++;
        if (rst_bit < 0) begin
            if (nbits >= N) exp_q.push_back(mosi_w);
            else exp_err++;
        end
        @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        if (rst_bit < 0) begin
            check_bit("busy_in_frame", busy, 1'b1);
            check_bit("oe_in_frame", spi_sdata_oe, 1'b1);
        end
        for (int k = 0; k < nbits; k++) begin
            if (k < N) mosi = mosi_w[bitpos(k)];
            else mosi = 1'b1;
            if (k == rst_bit) begin
                rstn = 1'b0;
                repeat (3) @(negedge clk);
                rstn = 1'b1;
            end
            repeat (4) @(negedge clk);
            if (rst_bit < 0) begin
                if (k < N) begin
                    miso_w[bitpos(k)] = spi_sdata_out;
                    mask[bitpos(k)]   = 1'b1;
                end else begin
                    check_bit("miso_after_frame", spi_sdata_out, 1'b0);
                end
            end
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (16) @(negedge clk);
        check_bit("busy_idle", busy, 1'b0);
        check_bit("oe_idle", spi_sdata_oe, 1'b0);
        check_bit("miso_idle", spi_sdata_out, 1'b0);
        if (rst_bit < 0) check_word("miso_word", miso_w & mask, tx_w & mask);
        check_int("rx_pending", exp_q.size(), 0);
        check_int("frame_err_count", err_seen, exp_err);
        check_int("tx_taken_count", taken_seen, exp_taken);
    endtask

    initial begin
        logic [N-1:0] m, m2, w;
        int           nb, sel;

        repeat (5) @(negedge clk);
        check_word("reset_rx_data", rx_data_out, '0);
        check_bit("reset_rx_valid", rx_data_valid, 1'b0);
        check_bit("reset_frame_err", frame_err, 1'b0);
        check_bit("reset_tx_taken", tx_taken, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_oe", spi_sdata_oe, 1'b0);
        check_bit("reset_miso", spi_sdata_out, 1'b0);
        rstn = 1'b1;
        repeat (10) @(negedge clk);

        spi_frame(32'hA5C30F81, 32'h12345678, N, -1, m);
        check_word("nominal_miso", m, 32'hA5C30F81);
        check_word("nominal_rx", rx_data_out, 32'h12345678);

        spi_frame(N'($urandom), N'($urandom), 12, -1, m);
        check_word("abort_rx_kept", rx_data_out, 32'h12345678);
        w = N'($urandom);
        spi_frame(N'($urandom), w, N, -1, m);
        check_word("after_abort_rx", rx_data_out, w);

        spi_frame(N'($urandom), 32'hDEADBEEF, N + 4, -1, m);
        check_word("overclock_rx", rx_data_out, 32'hDEADBEEF);

        spi_frame(N'($urandom), N'($urandom), N, 10, m);
        check_word("reset_mid_rx_cleared", rx_data_out, '0);
        spi_frame(N'($urandom), 32'h0000FFFF, N, -1, m);
        check_word("after_reset_rx", rx_data_out, 32'h0000FFFF);

        spi_frame(32'h00000001, N'($urandom), N, -1, m);
        spi_frame(32'h80000000, N'($urandom), N, -1, m2);
        check_word("b2b_miso_first", m, 32'h00000001);
        check_word("b2b_miso_second", m2, 32'h80000000);

`ifdef SPI_SLAVE_LSB_FIRST_EN
        spi_frame(N'($urandom), 32'h00000001, N, -1, m);
        check_word("first_bit_only_rx", rx_data_out, 32'h00000001);
`else
        spi_frame(N'($urandom), 32'h80000000, N, -1, m);
        check_word("first_bit_only_rx", rx_data_out, 32'h80000000);
`endif

        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 3);
            if (sel == 1) nb = $urandom_range(N + 1, N + 6);
            else if (sel == 2) nb = $urandom_range(1, N - 1);
            else nb = N;
            spi_frame(N'($urandom), N'($urandom), nb, -1, m);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
